dmem_arbiter: RTL and testbench

- Shares the byte-wide, big-endian 32-byte data memory between two word-access requesters: the processor load/store port (cpu_*) and a debug/loader port (dbg_*).
- Arbitrates between the ports round-robin.
- Serialises each 32-bit access into four byte accesses on the memory port, then returns read data with a done pulse.
- Sits between the processor datapath and the datmem array, replacing direct 4-byte parallel indexing.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a byte-wide, big-endian data memory between the CPU
// and debug word ports; each 32-bit access is serialised into four byte cycles.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    state_t            state, state_nx;
    logic [1:0]        cnt;
    logic              last;
    logic              sel;
    logic              win;
    logic              we_q;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wd_q;
    logic [23:0]       asm_q;

    // On a tie the port that did not win last time takes the grant.
    assign win = (cpu_req && dbg_req) ? ~last : dbg_req;

    always_comb begin
        state_nx  = state;
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        cpu_done  = 1'b0;
        dbg_done  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (rst_n && (cpu_req || dbg_req)) begin
                    state_nx = XFER;
                    if (win == PORT_DBG) dbg_gnt = 1'b1;
                    else                 cpu_gnt = 1'b1;
                end
            end
            XFER: begin
                if (cnt == 2'd3) state_nx = DONE;
                // Held quiet during reset so an aborted store writes nothing more.
                if (rst_n) begin
                    mem_en   = 1'b1;
                    mem_we   = we_q;
                    mem_addr = base + ADDR_W'(cnt);
                    case (cnt)
                        2'd0:    mem_wdata = wd_q[31:24];
                        2'd1:    mem_wdata = wd_q[23:16];
                        2'd2:    mem_wdata = wd_q[15:8];
                        default: mem_wdata = wd_q[7:0];
                    endcase
                end
            end
            DONE: begin
                cpu_done = (sel == PORT_CPU);
                dbg_done = (sel == PORT_DBG);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            last      <= PORT_DBG;
            sel       <= PORT_CPU;
            we_q      <= 1'b0;
            base      <= '0;
            wd_q      <= '0;
            asm_q     <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cpu_gnt || dbg_gnt) begin
                        sel  <= win;
                        last <= win;
                        we_q <= win ? dbg_we    : cpu_we;
                        base <= win ? dbg_addr  : cpu_addr;
                        wd_q <= win ? dbg_wdata : cpu_wdata;
                        cnt  <= 2'd0;
                    end
                end
                XFER: begin
                    cnt <= cnt + 2'd1;
                    if (!we_q) begin
                        case (cnt)
                            2'd0: asm_q[23:16] <= mem_rdata;
                            2'd1: asm_q[15:8]  <= mem_rdata;
                            2'd2: asm_q[7:0]   <= mem_rdata;
                            default: begin
                                // Last byte bypasses the assembly register so rdata is ready with done.
                                if (sel == PORT_DBG) dbg_rdata <= {asm_q, mem_rdata};
                                else                 cpu_rdata <= {asm_q, mem_rdata};
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction-level reference model is checked
// against the DUT every cycle, plus literal expectations for each scenario.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [4:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata;
    logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Physical memory driven by the DUT, plus a log of byte writes.
    logic [7:0]  tb_mem [32];
    logic [12:0] wlog [$];
    assign mem_rdata = tb_mem[mem_addr];

    initial begin
        for (int i = 0; i < 32; i++) tb_mem[i] = 8'h80 + 8'(i);
        tb_mem[8] = 8'h01; tb_mem[9] = 8'h02; tb_mem[10] = 8'h03; tb_mem[11] = 8'h04;
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) begin
                tb_mem[mem_addr] <= mem_wdata;
                wlog.push_back({mem_addr, mem_wdata});
            end
        end
    end

    // Reference model: m_k counts cycles since the grant edge (0 = free).
    logic [7:0]  ref_mem [32];
    int          m_k = 0;
    bit          m_own, m_we;
    bit          m_last = 1'b1;
    logic [4:0]  m_base;
    logic [31:0] m_wd;
    logic [31:0] m_rd [2];
    bit          cmp_on = 1'b0;

    function automatic bit win_dbg();
        return dbg_req && (!cpu_req || !m_last);
    endfunction

    function automatic logic [31:0] rd_word(input logic [4:0] a);
        logic [4:0] a1, a2, a3;
        a1 = a + 5'd1; a2 = a + 5'd2; a3 = a + 5'd3;
        return {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endfunction

    initial begin
        logic [4:0] wa;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h80 + 8'(i);
        ref_mem[8] = 8'h01; ref_mem[9] = 8'h02; ref_mem[10] = 8'h03; ref_mem[11] = 8'h04;
        m_rd[0] = '0; m_rd[1] = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_k = 0; m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
            end else if (m_k == 0) begin
                if (cpu_req || dbg_req) begin
                    m_own  = win_dbg();
                    m_last = m_own;
                    m_we   = m_own ? dbg_we    : cpu_we;
                    m_base = m_own ? dbg_addr  : cpu_addr;
                    m_wd   = m_own ? dbg_wdata : cpu_wdata;
                    m_k    = 1;
                end
            end else if (m_k <= 4) begin
                wa = m_base + 5'(m_k - 1);
                if (m_we) ref_mem[wa] = 8'(m_wd >> (8 * (4 - m_k)));
                if (m_k == 4 && !m_we) m_rd[m_own] = rd_word(m_base);
                m_k++;
            end else begin
                m_k = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit         arb, act, wd;
        logic [4:0] ea;
        logic [7:0] eb;
        if (cmp_on) begin
            arb = rst_n && m_k == 0 && (cpu_req || dbg_req);
            wd  = win_dbg();
            act = rst_n && m_k >= 1 && m_k <= 4;
            ea  = act ? m_base + 5'(m_k - 1) : 5'd0;
            eb  = act ? 8'(m_wd >> (8 * (4 - m_k))) : 8'd0;
            chk("cpu_gnt",   cpu_gnt,   arb && !wd);
            chk("dbg_gnt",   dbg_gnt,   arb && wd);
            chk("cpu_done",  cpu_done,  m_k == 5 && !m_own);
            chk("dbg_done",  dbg_done,  m_k == 5 && m_own);
            chk("mem_en",    mem_en,    act);
            chk("mem_we",    mem_we,    act && m_we);
            chk("mem_addr",  mem_addr,  ea);
            chk("mem_wdata", mem_wdata, eb);
            chk("cpu_rdata", cpu_rdata, m_rd[0]);
            chk("dbg_rdata", dbg_rdata, m_rd[1]);
        end
    end

    task automatic drive(input bit p, input bit we, input logic [4:0] a, input logic [31:0] d);
        if (p) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
        else   begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    endtask

    task automatic wait_gnt(input bit p);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = p ? dbg_gnt : cpu_gnt;
        end
        chk("grant_seen", got, 1);
    endtask

    task automatic wait_done(input bit p, output int lat);
        bit got = 1'b0;
        lat = -1;
        for (int i = 1; i <= 12 && !got; i++) begin
            @(negedge clk);
            if (p ? dbg_done : cpu_done) begin got = 1'b1; lat = i; end
        end
        chk("done_seen", got, 1);
    endtask

    // One word transaction; lat = cycles from grant edge to the done sample.
    task automatic xact(input bit p, input bit we, input logic [4:0] a,
                        input logic [31:0] d, output int lat);
        @(posedge clk); #1;
        drive(p, we, a, d);
        wait_gnt(p);
        @(posedge clk); #1;
        if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
        wait_done(p, lat);
    endtask

    initial begin
        int          lat, early, both, nd;
        logic [7:0]  e4 [4];
        logic [4:0]  ea3 [4];
        logic [7:0]  eb3 [4];
        logic [7:0]  e12 [4];
        int          gport [$];
        int          gcyc [$];
        int          xport [4];
        int          xcyc [4];

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #1 cmp_on = 1'b1;
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // CPU store then load of word 4
        xact(0, 1, 5'd4, 32'hDEADBEEF, lat);
        xact(0, 0, 5'd4, 32'h0, lat);
        chk("t1_latency", lat, 5);
        chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t1_dbg_rdata", dbg_rdata, 32'h0);
        e4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) chk("t1_mem", tb_mem[4 + i], e4[i]);

        // DBG store wrapping past the top of memory, then load back
        wlog.delete();
        xact(1, 1, 5'd30, 32'h11223344, lat);
        chk("t3_nwrites", wlog.size(), 4);
        ea3 = '{5'd30, 5'd31, 5'd0, 5'd1};
        eb3 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk("t3_waddr", 32'(wlog[i][12:8]), 32'(ea3[i]));
            chk("t3_wbyte", 32'(wlog[i][7:0]), 32'(eb3[i]));
        end
        xact(1, 0, 5'd30, 32'h0, lat);
        chk("t3_dbg_rdata", dbg_rdata, 32'h11223344);

        // Both ports requesting continuously out of reset
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        drive(0, 1, 5'd16, 32'hCAFEF00D);
        drive(1, 0, 5'd16, 32'h0);
        both = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (cpu_gnt && dbg_gnt) both++;
            if (cpu_gnt) begin gport.push_back(0); gcyc.push_back(n); end
            if (dbg_gnt) begin gport.push_back(1); gcyc.push_back(n); end
        end
        @(posedge clk); #1 cpu_req = 1'b0; dbg_req = 1'b0;
        chk("t2_simultaneous", both, 0);
        chk("t2_ngrants", gport.size(), 4);
        xport = '{0, 1, 0, 1};
        xcyc  = '{1, 7, 13, 19};
        for (int i = 0; i < 4; i++) begin
            chk("t2_port", gport[i], xport[i]);
            chk("t2_cycle", gcyc[i], xcyc[i]);
        end
        repeat (2) @(posedge clk);
        chk("t2_dbg_rdata", dbg_rdata, 32'hCAFEF00D);

        // DBG request raised while a CPU load is in flight
        @(posedge clk); #1;
        drive(0, 0, 5'd8, 32'h0);
        wait_gnt(0);
        @(posedge clk); #1 cpu_req = 1'b0;
        @(posedge clk); #1 drive(1, 0, 5'd8, 32'h0);
        early = 0; nd = 0;
        for (int i = 0; i < 12 && nd == 0; i++) begin
            @(negedge clk);
            if (dbg_gnt) early++;
            if (cpu_done) nd = 1;
        end
        chk("t4_cpu_done", nd, 1);
        chk("t4_dbg_gnt_early", early, 0);
        chk("t4_cpu_rdata", cpu_rdata, 32'h01020304);
        @(negedge clk);
        chk("t4_dbg_gnt_next", dbg_gnt, 1);
        @(posedge clk); #1 dbg_req = 1'b0;
        wait_done(1, lat);
        chk("t4_dbg_rdata", dbg_rdata, 32'h01020304);

        // CPU store leaves both rdata registers alone; CPU load updates only cpu_rdata
        xact(0, 1, 5'd20, 32'h55667788, lat);
        chk("t6_cpu_rdata_st", cpu_rdata, 32'h01020304);
        chk("t6_dbg_rdata_st", dbg_rdata, 32'h01020304);
        xact(0, 0, 5'd4, 32'h0, lat);
        chk("t6_cpu_rdata_ld", cpu_rdata, 32'hDEADBEEF);
        chk("t6_dbg_rdata_ld", dbg_rdata, 32'h01020304);

        // Reset during a DBG store after two bytes are written
        @(posedge clk); #1;
        drive(1, 1, 5'd12, 32'hAABBCCDD);
        wait_gnt(1);
        @(posedge clk); #1 dbg_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dbg_done) nd++;
        end
        chk("t5_no_done", nd, 0);
        chk("t5_mem_en", mem_en, 0);
        chk("t5_cpu_rdata", cpu_rdata, 32'h0);
        chk("t5_dbg_rdata", dbg_rdata, 32'h0);
        e12 = '{8'hAA, 8'hBB, 8'h8E, 8'h8F};
        for (int i = 0; i < 4; i++) chk("t5_mem", tb_mem[12 + i], e12[i]);
        xact(0, 0, 5'd12, 32'h0, lat);
        chk("t5_cpu_latency", lat, 5);
        chk("t5_cpu_rdata_ld", cpu_rdata, 32'hAABB8E8F);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
